// File: rtl/i2s_speaker_transmitter.sv
// I2S master transmitter: generates BCLK/LRCLK from clk and shifts stereo
// samples out MSB first with the standard one-bit delay after LRCLK changes.
// Sample pairs are buffered in a small FIFO and one pair is consumed per frame.
// A frame with nothing queued is sent as silence and flagged with underrun.
module i2s_speaker_transmitter #(
  parameter int CLK_DIV     = 2,
  parameter int SAMPLE_BITS = 18,
  parameter int SLOT_BITS   = 32,
  parameter int FIFO_DEPTH  = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SAMPLE_BITS-1:0] s_left,
  input  logic [SAMPLE_BITS-1:0] s_right,
  output logic                   BCLK,
  output logic                   LRCLK,
  output logic                   DIN,
  output logic                   frame_start,
  output logic                   underrun,
  output logic [LVL_W-1:0]       fifo_level
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BC_W       = $clog2(FRAME_BITS);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DIV_W-1:0]       div_cnt;
  logic                   started;
  logic [BC_W-1:0]        bit_cnt;
  logic [SAMPLE_BITS-1:0] left_w;
  logic [SAMPLE_BITS-1:0] right_w;
  logic [SAMPLE_BITS-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;

  logic                   tick;
  logic                   fall_evt;
  logic [BC_W-1:0]        next_bit;
  logic                   next_right;
  logic [BC_W-1:0]        slot_pos;
  logic [BC_W-1:0]        bit_idx;
  logic [SAMPLE_BITS-1:0] word_sel;
  logic [SAMPLE_BITS-1:0] word_shift;
  logic                   din_next;
  logic                   frame_load;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  // Bit-clock timing, slot position and the serial bit due at the next falling edge
  always_comb begin
    tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
    fall_evt   = tick && started && BCLK;
    next_bit   = (bit_cnt == BC_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BC_W'(1);
    next_right = (next_bit >= BC_W'(SLOT_BITS));
    slot_pos   = next_right ? (next_bit - BC_W'(SLOT_BITS)) : next_bit;
    bit_idx    = BC_W'(SAMPLE_BITS) - slot_pos;
    word_sel   = next_right ? right_w : left_w;
    word_shift = word_sel >> bit_idx;
    din_next   = 1'b0;
    if ((slot_pos != '0) && (slot_pos <= BC_W'(SAMPLE_BITS))) begin
      din_next = word_shift[0];
    end
    frame_load = fall_evt && (next_bit == '0);
    fifo_empty = (fifo_level == '0);
    s_ready    = (fifo_level < LVL_W'(FIFO_DEPTH));
    push       = s_valid && s_ready;
    pop        = frame_load && !fifo_empty;
  end

  // BCLK divider; the first toggle after reset is swallowed so BCLK idles high
  // for a full bit period and the first falling edge lands 2*CLK_DIV clocks in
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      started <= 1'b0;
      BCLK    <= 1'b1;
    end else if (tick) begin
      div_cnt <= '0;
      started <= 1'b1;
      if (started) begin
        BCLK <= ~BCLK;
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Frame sequencing on BCLK falling edges: bit counter, word select, data and frame pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt     <= BC_W'(FRAME_BITS - 1);
      LRCLK       <= 1'b1;
      DIN         <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      left_w      <= '0;
      right_w     <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall_evt) begin
        bit_cnt <= next_bit;
        LRCLK   <= next_right;
        DIN     <= din_next;
      end
      if (frame_load) begin
        frame_start <= 1'b1;
        if (fifo_empty) begin
          underrun <= 1'b1;
          left_w   <= '0;
          right_w  <= '0;
        end else begin
          left_w   <= mem_l[rd_ptr];
          right_w  <= mem_r[rd_ptr];
        end
      end
    end
  end

  // FIFO pointers and occupancy; a refused push while full leaves the source holding data
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= s_left;
      mem_r[wr_ptr] <= s_right;
    end
  end

endmodule
